vram_scheduler: RTL and testbench

//  Time-multiplexes one single-port, synchronous-read video RAM between VGA scanout and a CPU requester.

---
 rtl/vram_scheduler_if.sv | 23 ++
 rtl/vram_scheduler.sv | 103 ++++++++++
 tb/tb_vram_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_scheduler_if.sv
// CPU-side request/acknowledge bus of the VRAM scheduler.
// The CPU holds addr/we/wdata stable until it sees the ack pulse.
interface vram_scheduler_if #(
  parameter int ABITS = 19,
  parameter int DBITS = 4
);
  logic             cpu_req;
  logic             cpu_we;
  logic [ABITS-1:0] cpu_addr;
  logic [DBITS-1:0] cpu_wdata;
  logic             cpu_ack;
  logic [DBITS-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vram_scheduler.sv
// Shares one single-port synchronous-read VRAM between VGA scanout and a CPU.
// Two clocks after each pixel tick is reserved for the display fetch; the CPU uses every other cycle.
module vram_scheduler #(
  parameter int XBITS = 10,
  parameter int YBITS = 10,
  parameter int ABITS = 19,
  parameter int DBITS = 4,
  parameter int HVIS  = 640
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic [XBITS-1:0] x_i,
  input  logic [YBITS-1:0] y_i,
  input  logic             activevideo_i,
  vram_scheduler_if.slave  cpu,
  output logic [ABITS-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [DBITS-1:0] mem_wdata_o,
  input  logic [DBITS-1:0] mem_rdata_i,
  output logic [DBITS-1:0] pix_color_o
);

  localparam logic [ABITS-1:0] HVIS_A = ABITS'(HVIS);

  typedef enum logic {IDLE, ACK} state_e;

  state_e           state_q, state_d;
  logic             tickD1_q, tickD2_q, tickD3_q;
  logic             dispEn_q, fetchEn_q;
  logic [ABITS-1:0] dispAddr_q;
  logic [ABITS-1:0] memAddr_q, memAddr_d;
  logic [DBITS-1:0] memWdata_q, memWdata_d;
  logic             lastWe_q, lastWe_d;
  logic [DBITS-1:0] pixColor_q;
  logic             protect, issue, ack;

  // The tick shift chain alone locates the display slot, so a late or early tick re-aligns it at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tickD1_q   <= 1'b0;
      tickD2_q   <= 1'b0;
      tickD3_q   <= 1'b0;
      dispEn_q   <= 1'b0;
      fetchEn_q  <= 1'b0;
      dispAddr_q <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      lastWe_q   <= 1'b0;
      pixColor_q <= '0;
      state_q    <= IDLE;
    end else begin
      tickD1_q  <= tick_i;
      tickD2_q  <= tickD1_q;
      tickD3_q  <= tickD2_q;
      fetchEn_q <= tickD2_q & dispEn_q;
      if (tickD1_q) begin
        dispAddr_q <= ABITS'(y_i) * HVIS_A + ABITS'(x_i);
        dispEn_q   <= activevideo_i;
      end
      if (tickD3_q) begin
        pixColor_q <= fetchEn_q ? mem_rdata_i : '0;
      end
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      lastWe_q   <= lastWe_d;
      state_q    <= state_d;
    end
  end

  // Blanking display slots are left free for the CPU; only a visible fetch blocks it.
  always_comb begin
    protect    = tickD2_q & dispEn_q;
    issue      = reset_n & (state_q == IDLE) & cpu.cpu_req & ~protect;
    ack        = reset_n & (state_q == ACK);
    state_d    = state_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    lastWe_d   = lastWe_q;

    case (state_q)
      IDLE:    if (issue) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (protect) begin
      memAddr_d = dispAddr_q;
    end else if (issue) begin
      memAddr_d  = cpu.cpu_addr;
      memWdata_d = cpu.cpu_wdata;
      lastWe_d   = cpu.cpu_we;
    end
  end

  assign mem_addr_o    = reset_n ? memAddr_d : '0;
  assign mem_wdata_o   = reset_n ? memWdata_d : '0;
  assign mem_we_o      = issue & cpu.cpu_we;
  assign cpu.cpu_ack   = ack;
  assign cpu.cpu_rdata = (ack && !lastWe_q) ? mem_rdata_i : '0;
  assign pix_color_o   = reset_n ? pixColor_q : '0;

endmodule

// File: tb/tb_vram_scheduler.sv
// Directed bench for vram_scheduler with a small VRAM model and an ack scoreboard.
// Directed checks cover slot timing; a monitor compares every ack against queued expectations.
module tb_vram_scheduler;

  localparam int ABITS = 19;
  localparam int DBITS = 4;

  typedef struct {
    int         cyc;
    logic [3:0] rdata;
  } exp_t;

  logic             clk;
  logic             resetN;
  logic             tick;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             av;
  logic [ABITS-1:0] memAddr;
  logic             memWe;
  logic [DBITS-1:0] memWdata;
  logic [DBITS-1:0] memRdata;
  logic [DBITS-1:0] pixColor;
  logic             preload;
  logic [3:0]       vram [0:1023];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   lastAck = -1;
  int   t;
  exp_t expQ[$];
  exp_t monE;

  vram_scheduler_if #(.ABITS(ABITS), .DBITS(DBITS)) cpuBus ();

  vram_scheduler dut (
    .clk          (clk),
    .reset_n      (resetN),
    .tick_i       (tick),
    .x_i          (x),
    .y_i          (y),
    .activevideo_i(av),
    .cpu          (cpuBus),
    .mem_addr_o   (memAddr),
    .mem_we_o     (memWe),
    .mem_wdata_o  (memWdata),
    .mem_rdata_i  (memRdata),
    .pix_color_o  (pixColor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read VRAM: data appears one clock after the address.
  always @(posedge clk) begin
    memRdata <= vram[memAddr[9:0]];
    if (preload) begin
      vram[641] <= 4'hA;
      vram[7]   <= 4'h9;
    end else if (memWe) begin
      vram[memAddr[9:0]] <= memWdata;
    end
  end

  // Monitor: every ack must match the next queued expectation in cycle and data, and acks never touch.
  always @(negedge clk) begin
    if (cpuBus.cpu_ack === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL ack_unexpected: ack at cycle %0d, none expected", cyc);
      end else begin
        monE = expQ.pop_front();
        if (monE.cyc != cyc || monE.rdata !== cpuBus.cpu_rdata) begin
          errors++;
          $display("[TB] FAIL ack: got cycle %0d rdata %h, expected cycle %0d rdata %h",
                   cyc, cpuBus.cpu_rdata, monE.cyc, monE.rdata);
        end
      end
      if (lastAck >= 0) begin
        checks++;
        if (cyc == lastAck + 1) begin
          errors++;
          $display("[TB] FAIL ack_adjacent: acks at cycles %0d and %0d, expected a gap", lastAck, cyc);
        end
      end
      lastAck = cyc;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [ABITS-1:0] addr,
                               input logic [DBITS-1:0] wdata);
    cpuBus.cpu_req   = req;
    cpuBus.cpu_we    = we;
    cpuBus.cpu_addr  = addr;
    cpuBus.cpu_wdata = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  initial begin
    resetN  = 1'b0;
    preload = 1'b1;
    tick    = 1'b0;
    x       = '0;
    y       = '0;
    av      = 1'b0;
    applyStimulus(1'b1, 1'b0, 19'd3, 4'h0);

    // Reset held three clocks with a request pending.
    repeat (3) begin
      nextCycle();
      @(negedge clk);
      checkOutput("reset_ack", 32'(cpuBus.cpu_ack), 32'h0);
      checkOutput("reset_we", 32'(memWe), 32'h0);
      checkOutput("reset_pix", 32'(pixColor), 32'h0);
    end
    nextCycle();
    resetN  = 1'b1;
    preload = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    nextCycle();
    nextCycle();

    // Scanout of pixel (1,1).
    nextCycle();
    t = cyc;
    tick = 1'b1;
    nextCycle();
    tick = 1'b0; x = 10'd1; y = 10'd1; av = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("scan_addr", 32'(memAddr), 32'd641);
    checkOutput("scan_we", 32'(memWe), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("scan_pix_early", 32'(pixColor), 32'h0);
    for (int k = 4; k < 8; k++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("scan_pix", 32'(pixColor), 32'hA);
    end

    // CPU write arriving in the display slot waits one clock.
    nextCycle();
    t = cyc;
    tick = 1'b1;
    nextCycle();
    tick = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 19'd5, 4'h3);
    expQ.push_back('{t + 4, 4'h0});
    @(negedge clk);
    checkOutput("cont_slot_addr", 32'(memAddr), 32'd641);
    checkOutput("cont_slot_we", 32'(memWe), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("cont_issue_we", 32'(memWe), 32'h1);
    checkOutput("cont_issue_addr", 32'(memAddr), 32'd5);
    checkOutput("cont_issue_wdata", 32'(memWdata), 32'h3);
    nextCycle();
    @(negedge clk);
    checkOutput("cont_pix", 32'(pixColor), 32'hA);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    nextCycle();
    checkOutput("cont_vram5", 32'(vram[5]), 32'h3);

    // CPU read in a blanking display slot issues immediately.
    nextCycle();
    t = cyc;
    tick = 1'b1;
    nextCycle();
    tick = 1'b0; x = 10'd700; y = 10'd1; av = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 1'b0, 19'd7, 4'h0);
    expQ.push_back('{t + 3, 4'h9});
    @(negedge clk);
    checkOutput("blank_addr", 32'(memAddr), 32'd7);
    checkOutput("blank_we", 32'(memWe), 32'h0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("blank_pix", 32'(pixColor), 32'h0);

    // Request held eight clocks across a visible tick.
    nextCycle();
    nextCycle();
    t = cyc;
    tick = 1'b1;
    applyStimulus(1'b1, 1'b0, 19'd7, 4'h0);
    expQ.push_back('{t + 1, 4'h9});
    expQ.push_back('{t + 4, 4'h9});
    expQ.push_back('{t + 6, 4'h9});
    expQ.push_back('{t + 8, 4'h9});
    nextCycle();
    tick = 1'b0; x = 10'd1; y = 10'd1; av = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_slot_addr", 32'(memAddr), 32'd641);
    checkOutput("b2b_slot_we", 32'(memWe), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_after_addr", 32'(memAddr), 32'd7);
    repeat (5) nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);

    // Reset during the ACK cycle suppresses the ack; a new request then completes.
    nextCycle();
    nextCycle();
    t = cyc;
    applyStimulus(1'b1, 1'b0, 19'd7, 4'h0);
    nextCycle();
    resetN = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("rst_mid_ack", 32'(cpuBus.cpu_ack), 32'h0);
    nextCycle();
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_pix", 32'(pixColor), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 19'd9, 4'h5);
    expQ.push_back('{t + 4, 4'h0});
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    nextCycle();
    nextCycle();
    checkOutput("rst_vram9", 32'(vram[9]), 32'h5);
    checkOutput("acks_outstanding", 32'(expQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
